vga_timing_gen: RTL



---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_axis_counter.sv | 50 +++++
 rtl/vga_timing_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA timing generator.
// Defaults describe 640x480@60 timing.
package vga_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;

    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam bit VGA_HS_POL = 1'b0;
    localparam bit VGA_VS_POL = 1'b0;

    localparam int unsigned VGA_COLOR_W = 4;

    typedef struct packed {
        logic [VGA_COLOR_W-1:0] r;
        logic [VGA_COLOR_W-1:0] g;
        logic [VGA_COLOR_W-1:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Single raster axis: wrapping position counter with an advance enable,
// a terminal-count flag and combinational active/sync region decode.
module vga_axis_counter #(
    parameter int unsigned TOTAL  = 800,
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FP     = 16,
    parameter int unsigned SYNC   = 96,
    parameter int unsigned W      = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         adv,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         active,
    output logic         sync
);

    // One spare bit so bounds equal to TOTAL never alias to zero.
    localparam logic [W:0] LAST     = (W+1)'(TOTAL - 1);
    localparam logic [W:0] ACT_END  = (W+1)'(ACTIVE);
    localparam logic [W:0] SYNC_BEG = (W+1)'(ACTIVE + FP);
    localparam logic [W:0] SYNC_END = (W+1)'(ACTIVE + FP + SYNC);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W:0]   cnt_ext;

    assign cnt_ext = {1'b0, cnt_q};
    assign wrap    = (cnt_ext == LAST);
    assign active  = (cnt_ext < ACT_END);
    assign sync    = (cnt_ext >= SYNC_BEG) && (cnt_ext < SYNC_END);
    assign cnt     = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (adv) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with registered sync/DE/colour output stage.
// Optional colour-bar test pattern (and BAR_SHIFT, test_mode) with VGA_TEST_PATTERN_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
    parameter int unsigned H_FP      = VGA_H_FP,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BP      = VGA_H_BP,
    parameter int unsigned V_ACTIVE  = VGA_V_ACTIVE,
    parameter int unsigned V_FP      = VGA_V_FP,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BP      = VGA_V_BP,
    parameter bit          HS_POL    = VGA_HS_POL,
    parameter bit          VS_POL    = VGA_VS_POL,
    parameter int unsigned COLOR_W   = VGA_COLOR_W,
`ifdef VGA_TEST_PATTERN_EN
    parameter int unsigned BAR_SHIFT = 6,
`endif
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned X_W     = $clog2(H_TOTAL),
    localparam int unsigned Y_W     = $clog2(V_TOTAL)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pix_en,
    output logic [X_W-1:0]       x,
    output logic [Y_W-1:0]       y,
    output logic                 fetch_valid,
    input  logic [3*COLOR_W-1:0] rgb_in,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                 test_mode,
`endif
    output logic                 vga_hs,
    output logic                 vga_vs,
    output logic                 vga_de,
    output logic [COLOR_W-1:0]   vga_r,
    output logic [COLOR_W-1:0]   vga_g,
    output logic [COLOR_W-1:0]   vga_b,
    output logic                 frame_start,
    output logic                 line_start
);

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } pix_t;

    logic h_wrap;
    logic h_active;
    logic h_sync;
    logic v_active;
    logic v_sync;
    logic v_wrap_unused;

    vga_axis_counter #(
        .TOTAL  (H_TOTAL),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .W      (X_W)
    ) u_h_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv    (pix_en),
        .cnt    (x),
        .wrap   (h_wrap),
        .active (h_active),
        .sync   (h_sync)
    );

    vga_axis_counter #(
        .TOTAL  (V_TOTAL),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .W      (Y_W)
    ) u_v_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv    (pix_en & h_wrap),
        .cnt    (y),
        .wrap   (v_wrap_unused),
        .active (v_active),
        .sync   (v_sync)
    );

    assign fetch_valid = h_active & v_active;

    logic de_q, de_d;
    logic hs_q, hs_d;
    logic vs_q, vs_d;
    logic frame_start_q, frame_start_d;
    logic line_start_q, line_start_d;
    pix_t pix_q, pix_d;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;
    pix_t       bar_pix;

    assign bar       = x[BAR_SHIFT+2:BAR_SHIFT];
    assign bar_pix.r = {COLOR_W{bar[2]}};
    assign bar_pix.g = {COLOR_W{bar[1]}};
    assign bar_pix.b = {COLOR_W{bar[0]}};
`endif

    // Output stage decodes the counters before they advance on the same edge.
    always_comb begin
        de_d          = de_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        pix_d         = pix_q;
        frame_start_d = 1'b0;
        line_start_d  = 1'b0;
        if (pix_en) begin
            de_d          = h_active & v_active;
            hs_d          = h_sync ? HS_POL : ~HS_POL;
            vs_d          = v_sync ? VS_POL : ~VS_POL;
            frame_start_d = (x == '0) && (y == '0);
            line_start_d  = (x == '0) && v_active;
            pix_d         = '0;
            if (h_active && v_active) begin
`ifdef VGA_TEST_PATTERN_EN
                pix_d = test_mode ? bar_pix : pix_t'(rgb_in);
`else
                pix_d = pix_t'(rgb_in);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q          <= 1'b0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            pix_q         <= '0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            de_q          <= de_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            pix_q         <= pix_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
        end
    end

    assign vga_de      = de_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_r       = pix_q.r;
    assign vga_g       = pix_q.g;
    assign vga_b       = pix_q.b;
    assign frame_start = frame_start_q;
    assign line_start  = line_start_q;

endmodule
